// File: rtl/cpu_pkg.sv
// Shared encodings for the single-bus CPU control path: opcodes, sequencer
// states, IR field positions, ALU select codes and opcode classification.
package cpu_pkg;

    typedef enum logic [4:0] {
        OP_LD   = 5'd0,
        OP_LDI  = 5'd1,
        OP_ST   = 5'd2,
        OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_SHR  = 5'd7,
        OP_SHL  = 5'd8,
        OP_ROR  = 5'd9,
        OP_ROL  = 5'd10,
        OP_ADDI = 5'd11,
        OP_ANDI = 5'd12,
        OP_ORI  = 5'd13,
        OP_MUL  = 5'd14,
        OP_DIV  = 5'd15,
        OP_NEG  = 5'd16,
        OP_NOT  = 5'd17,
        OP_NOP  = 5'd18,
        OP_HALT = 5'd19
    } opcode_e;

    // Encodings equal the externally visible step number.
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_IDLE = 4'd8,
        S_HALT = 4'd15
    } state_e;

    typedef enum logic [3:0] {
        CLS_ALU_REG,
        CLS_ALU_IMM,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned RA_HI  = 26;
    localparam int unsigned RA_LO  = 23;
    localparam int unsigned RB_HI  = 22;
    localparam int unsigned RB_LO  = 19;
    localparam int unsigned RC_HI  = 18;
    localparam int unsigned RC_LO  = 15;
    localparam int unsigned IMM_HI = 18;
    localparam int unsigned IMM_LO = 0;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SHR  = 5'd5;
    localparam logic [4:0] ALU_SHL  = 5'd6;
    localparam logic [4:0] ALU_ROR  = 5'd7;
    localparam logic [4:0] ALU_ROL  = 5'd8;
    localparam logic [4:0] ALU_MUL  = 5'd9;
    localparam logic [4:0] ALU_DIV  = 5'd10;
    localparam logic [4:0] ALU_NEG  = 5'd11;
    localparam logic [4:0] ALU_NOT  = 5'd12;

    function automatic op_class_e op_class(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU_REG;
            OP_ADDI, OP_ANDI, OP_ORI:       return CLS_ALU_IMM;
            OP_NEG, OP_NOT:                 return CLS_UNARY;
            OP_MUL, OP_DIV:                 return CLS_MULDIV;
            OP_LD:                          return CLS_LD;
            OP_LDI:                         return CLS_LDI;
            OP_ST:                          return CLS_ST;
            OP_NOP:                         return CLS_NOP;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILLEGAL;
        endcase
    endfunction

    // Address arithmetic for ld/ldi/st uses the adder.
    function automatic logic [4:0] alu_code(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: return ALU_ADD;
            OP_SUB:                                return ALU_SUB;
            OP_AND, OP_ANDI:                       return ALU_AND;
            OP_OR, OP_ORI:                         return ALU_OR;
            OP_SHR:                                return ALU_SHR;
            OP_SHL:                                return ALU_SHL;
            OP_ROR:                                return ALU_ROR;
            OP_ROL:                                return ALU_ROL;
            OP_MUL:                                return ALU_MUL;
            OP_DIV:                                return ALU_DIV;
            OP_NEG:                                return ALU_NEG;
            OP_NOT:                                return ALU_NOT;
            default:                               return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decode.sv
// 4-to-16 one-hot register select decoder; all-zero when not enabled.
module reg_select_decode (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle T0..T7 control sequencer for the single-bus CPU datapath.
// All outputs are decoded from the registered state and the IR only.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ALU_SEL_W = 5
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 run,
    input  logic                 stop,
    input  logic [31:0]          ir,
    input  logic                 mem_done,
    output logic                 pc_out,
    output logic                 zhigh_out,
    output logic                 zlow_out,
    output logic                 mdr_out,
    output logic                 c_out,
    output logic                 pc_in,
    output logic                 inc_pc,
    output logic                 ir_in,
    output logic                 mar_in,
    output logic                 mdr_in,
    output logic                 y_in,
    output logic                 z_in,
    output logic                 hi_in,
    output logic                 lo_in,
    output logic                 read,
    output logic                 write,
    output logic [15:0]          reg_in,
    output logic [15:0]          reg_out,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic [3:0]           step,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal
);

    state_e      state_q, state_d;
    op_class_e   cls;
    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    logic [3:0]  in_sel, out_sel;
    logic        in_en, out_en, alu_en, last;
    logic        unused_imm;

    assign opc        = ir[OPC_HI:OPC_LO];
    assign ra         = ir[RA_HI:RA_LO];
    assign rb         = ir[RB_HI:RB_LO];
    assign rc         = ir[RC_HI:RC_LO];
    assign unused_imm = ^ir[RC_LO-1:IMM_LO];
    assign cls        = op_class(opc);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last      = 1'b0;
        pc_out    = 1'b0;
        zhigh_out = 1'b0;
        zlow_out  = 1'b0;
        mdr_out   = 1'b0;
        c_out     = 1'b0;
        pc_in     = 1'b0;
        inc_pc    = 1'b0;
        ir_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        illegal   = 1'b0;
        alu_en    = 1'b0;
        in_en     = 1'b0;
        in_sel    = ra;
        out_en    = 1'b0;
        out_sel   = rb;

        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
                if (mem_done) state_d = S_T2;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                if (cls == CLS_HALT)     state_d = S_HALT;
                else if (cls == CLS_NOP) last    = 1'b1;
                else                     state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    CLS_ALU_REG, CLS_ALU_IMM: begin
                        out_en = 1'b1;
                        y_in   = 1'b1;
                    end
                    CLS_UNARY: begin
                        out_en = 1'b1;
                        alu_en = 1'b1;
                        z_in   = 1'b1;
                    end
                    CLS_MULDIV: begin
                        out_sel = ra;
                        out_en  = 1'b1;
                        y_in    = 1'b1;
                    end
                    // Rb=0 means no base: bus left undriven reads as zero.
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        out_en = (rb != 4'd0);
                        y_in   = 1'b1;
                    end
                    CLS_ILLEGAL: begin
                        illegal = 1'b1;
                        last    = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    CLS_ALU_REG: begin
                        out_sel = rc;
                        out_en  = 1'b1;
                        alu_en  = 1'b1;
                        z_in    = 1'b1;
                    end
                    CLS_ALU_IMM, CLS_LD, CLS_LDI, CLS_ST: begin
                        c_out  = 1'b1;
                        alu_en = 1'b1;
                        z_in   = 1'b1;
                    end
                    CLS_UNARY: begin
                        zlow_out = 1'b1;
                        in_en    = 1'b1;
                        last     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        out_en = 1'b1;
                        alu_en = 1'b1;
                        z_in   = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_T5: begin
                state_d = S_T6;
                case (cls)
                    CLS_ALU_REG, CLS_ALU_IMM, CLS_LDI: begin
                        zlow_out = 1'b1;
                        in_en    = 1'b1;
                        last     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        zlow_out = 1'b1;
                        lo_in    = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        zlow_out = 1'b1;
                        mar_in   = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_T6: begin
                case (cls)
                    CLS_MULDIV: begin
                        zhigh_out = 1'b1;
                        hi_in     = 1'b1;
                        last      = 1'b1;
                    end
                    CLS_LD: begin
                        read   = 1'b1;
                        mdr_in = 1'b1;
                        if (mem_done) state_d = S_T7;
                    end
                    CLS_ST: begin
                        out_sel = ra;
                        out_en  = 1'b1;
                        mdr_in  = 1'b1;
                        state_d = S_T7;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_T7: begin
                case (cls)
                    CLS_LD: begin
                        mdr_out = 1'b1;
                        in_en   = 1'b1;
                        last    = 1'b1;
                    end
                    CLS_ST: begin
                        write = 1'b1;
                        if (mem_done) last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        if (last) begin
            state_d = stop ? S_IDLE : S_T0;
        end
    end

    assign step    = state_q;
    assign busy    = ~state_q[3];
    assign halted  = (state_q == S_HALT);
    assign alu_sel = alu_en ? ALU_SEL_W'(alu_code(opc)) : '0;

    reg_select_decode u_in_decode (
        .sel    (in_sel),
        .en     (in_en),
        .onehot (reg_in)
    );

    reg_select_decode u_out_decode (
        .sel    (out_sel),
        .en     (out_en),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus hand-written
// sequences for asynchronous clear in HALT and mid memory handshake.
module tb_control_sequencer;

    localparam logic [18:0] PCO = 19'h40000;
    localparam logic [18:0] ZHO = 19'h20000;
    localparam logic [18:0] ZLO = 19'h10000;
    localparam logic [18:0] MDO = 19'h08000;
    localparam logic [18:0] CO  = 19'h04000;
    localparam logic [18:0] PCI = 19'h02000;
    localparam logic [18:0] INC = 19'h01000;
    localparam logic [18:0] IRI = 19'h00800;
    localparam logic [18:0] MAI = 19'h00400;
    localparam logic [18:0] MDI = 19'h00200;
    localparam logic [18:0] YI  = 19'h00100;
    localparam logic [18:0] ZI  = 19'h00080;
    localparam logic [18:0] HII = 19'h00040;
    localparam logic [18:0] LOI = 19'h00020;
    localparam logic [18:0] RD  = 19'h00010;
    localparam logic [18:0] WR  = 19'h00008;
    localparam logic [18:0] BSY = 19'h00004;
    localparam logic [18:0] HLT = 19'h00002;
    localparam logic [18:0] ILL = 19'h00001;

    localparam logic [18:0] F0 = PCO | MAI | INC | ZI | BSY;
    localparam logic [18:0] F1 = ZLO | PCI | RD | MDI | BSY;
    localparam logic [18:0] F2 = MDO | IRI | BSY;

    localparam logic [31:0] IR_ADD  = {5'd3,  4'd3,  4'd4,  4'd5, 15'd0};
    localparam logic [31:0] IR_LD   = {5'd0,  4'd7,  4'd0,  19'h7FFFF};
    localparam logic [31:0] IR_ST   = {5'd2,  4'd9,  4'd2,  19'd5};
    localparam logic [31:0] IR_MUL  = {5'd14, 4'd1,  4'd6,  19'd0};
    localparam logic [31:0] IR_NEG  = {5'd16, 4'd10, 4'd11, 19'd0};
    localparam logic [31:0] IR_LDI  = {5'd1,  4'd2,  4'd3,  19'd100};
    localparam logic [31:0] IR_ORI  = {5'd13, 4'd5,  4'd0,  19'd1};
    localparam logic [31:0] IR_NOP  = {5'd18, 27'd0};
    localparam logic [31:0] IR_BAD  = {5'd31, 27'd0};
    localparam logic [31:0] IR_HALT = {5'd19, 27'd0};

    typedef struct {
        logic [31:0] ir;
        logic        run;
        logic        stop;
        logic        md;
        logic [3:0]  step;
        logic [18:0] ctrl;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr, run, stop, mem_done;
    logic [31:0] ir;
    logic        pc_out, zhigh_out, zlow_out, mdr_out, c_out;
    logic        pc_in, inc_pc, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
    logic        read, write, busy, halted, illegal;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  alu_sel;
    logic [3:0]  step;
    logic [18:0] ctrl;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    vec_t        tbl[$];

    control_sequencer #(.ALU_SEL_W(5)) dut (
        .clk(clk), .clr(clr), .run(run), .stop(stop), .ir(ir), .mem_done(mem_done),
        .pc_out(pc_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .mdr_out(mdr_out), .c_out(c_out), .pc_in(pc_in), .inc_pc(inc_pc),
        .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in),
        .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .read(read), .write(write),
        .reg_in(reg_in), .reg_out(reg_out), .alu_sel(alu_sel), .step(step),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    assign ctrl = {pc_out, zhigh_out, zlow_out, mdr_out, c_out, pc_in, inc_pc,
                   ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, read, write,
                   busy, halted, illegal};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    task automatic add(input logic [31:0] i, input logic r, input logic s,
                       input logic m, input logic [3:0] st, input logic [18:0] c,
                       input logic [15:0] ri, input logic [15:0] ro,
                       input logic [4:0] a);
        vec_t v;
        v.ir = i; v.run = r; v.stop = s; v.md = m;
        v.step = st; v.ctrl = c; v.rin = ri; v.rout = ro; v.alu = a;
        tbl.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] i, input logic s);
        add(i, 1'b0, s, 1'b1, 4'd0, F0, 16'h0, 16'h0, 5'd0);
        add(i, 1'b0, s, 1'b1, 4'd1, F1, 16'h0, 16'h0, 5'd0);
        add(i, 1'b0, s, 1'b1, 4'd2, F2, 16'h0, 16'h0, 5'd0);
    endtask

    initial begin
        bit reached;

        clr = 1'b0; run = 1'b0; stop = 1'b0; mem_done = 1'b0; ir = '0;

        // Fetch with three wait cycles in T1, then add R3 = R4 + R5.
        add(IR_ADD, 1, 0, 0, 4'd8, 19'h0, 16'h0, 16'h0, 5'd0);
        add(IR_ADD, 0, 0, 0, 4'd0, F0, 16'h0, 16'h0, 5'd0);
        add(IR_ADD, 0, 0, 0, 4'd1, F1, 16'h0, 16'h0, 5'd0);
        add(IR_ADD, 0, 0, 0, 4'd1, F1, 16'h0, 16'h0, 5'd0);
        add(IR_ADD, 0, 0, 0, 4'd1, F1, 16'h0, 16'h0, 5'd0);
        add(IR_ADD, 0, 0, 1, 4'd1, F1, 16'h0, 16'h0, 5'd0);
        add(IR_ADD, 0, 0, 0, 4'd2, F2, 16'h0, 16'h0, 5'd0);
        add(IR_ADD, 1, 0, 0, 4'd3, YI | BSY, 16'h0, 16'h0010, 5'd0);
        add(IR_ADD, 0, 0, 0, 4'd4, ZI | BSY, 16'h0, 16'h0020, 5'd1);
        add(IR_ADD, 0, 0, 0, 4'd5, ZLO | BSY, 16'h0008, 16'h0, 5'd0);
        fetch(IR_ADD, 0);
        add(IR_ADD, 0, 0, 1, 4'd3, YI | BSY, 16'h0, 16'h0010, 5'd0);
        add(IR_ADD, 0, 0, 1, 4'd4, ZI | BSY, 16'h0, 16'h0020, 5'd1);
        add(IR_ADD, 0, 0, 1, 4'd5, ZLO | BSY, 16'h0008, 16'h0, 5'd0);
        // ld R7, 0x7FFFF with no base and a two-cycle stall in T6.
        fetch(IR_LD, 0);
        add(IR_LD, 0, 0, 1, 4'd3, YI | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_LD, 0, 0, 1, 4'd4, CO | ZI | BSY, 16'h0, 16'h0, 5'd1);
        add(IR_LD, 0, 0, 1, 4'd5, ZLO | MAI | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_LD, 0, 0, 0, 4'd6, RD | MDI | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_LD, 0, 0, 0, 4'd6, RD | MDI | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_LD, 0, 0, 1, 4'd6, RD | MDI | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_LD, 0, 0, 1, 4'd7, MDO | BSY, 16'h0080, 16'h0, 5'd0);
        // st R9, 5(R2) with stop held: ends in IDLE.
        fetch(IR_ST, 1);
        add(IR_ST, 0, 1, 1, 4'd3, YI | BSY, 16'h0, 16'h0004, 5'd0);
        add(IR_ST, 0, 1, 1, 4'd4, CO | ZI | BSY, 16'h0, 16'h0, 5'd1);
        add(IR_ST, 0, 1, 1, 4'd5, ZLO | MAI | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_ST, 0, 1, 1, 4'd6, MDI | BSY, 16'h0, 16'h0200, 5'd0);
        add(IR_ST, 0, 1, 0, 4'd7, WR | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_ST, 0, 1, 1, 4'd7, WR | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_ST, 0, 1, 1, 4'd8, 19'h0, 16'h0, 16'h0, 5'd0);
        add(IR_MUL, 1, 0, 1, 4'd8, 19'h0, 16'h0, 16'h0, 5'd0);
        // mul R1, R6; stop pulsed mid-instruction must not be latched.
        fetch(IR_MUL, 0);
        add(IR_MUL, 0, 0, 1, 4'd3, YI | BSY, 16'h0, 16'h0002, 5'd0);
        add(IR_MUL, 0, 1, 1, 4'd4, ZI | BSY, 16'h0, 16'h0040, 5'd9);
        add(IR_MUL, 0, 0, 1, 4'd5, ZLO | LOI | BSY, 16'h0, 16'h0, 5'd0);
        add(IR_MUL, 0, 0, 1, 4'd6, ZHO | HII | BSY, 16'h0, 16'h0, 5'd0);
        fetch(IR_NEG, 0);
        add(IR_NEG, 0, 0, 1, 4'd3, ZI | BSY, 16'h0, 16'h0800, 5'd11);
        add(IR_NEG, 0, 0, 1, 4'd4, ZLO | BSY, 16'h0400, 16'h0, 5'd0);
        fetch(IR_LDI, 0);
        add(IR_LDI, 0, 0, 1, 4'd3, YI | BSY, 16'h0, 16'h0008, 5'd0);
        add(IR_LDI, 0, 0, 1, 4'd4, CO | ZI | BSY, 16'h0, 16'h0, 5'd1);
        add(IR_LDI, 0, 0, 1, 4'd5, ZLO | BSY, 16'h0004, 16'h0, 5'd0);
        // ori with Rb=0 still drives R0: base suppression is ld/ldi/st only.
        fetch(IR_ORI, 0);
        add(IR_ORI, 0, 0, 1, 4'd3, YI | BSY, 16'h0, 16'h0001, 5'd0);
        add(IR_ORI, 0, 0, 1, 4'd4, CO | ZI | BSY, 16'h0, 16'h0, 5'd4);
        add(IR_ORI, 0, 0, 1, 4'd5, ZLO | BSY, 16'h0020, 16'h0, 5'd0);
        fetch(IR_NOP, 0);
        fetch(IR_BAD, 0);
        add(IR_BAD, 0, 0, 1, 4'd3, ILL | BSY, 16'h0, 16'h0, 5'd0);
        fetch(IR_HALT, 0);
        add(IR_HALT, 1, 0, 1, 4'd15, HLT, 16'h0, 16'h0, 5'd0);
        add(IR_HALT, 1, 0, 1, 4'd15, HLT, 16'h0, 16'h0, 5'd0);
        add(IR_HALT, 0, 0, 1, 4'd15, HLT, 16'h0, 16'h0, 5'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_step", -1, 32'(step), 32'd8);
        check("reset_ctrl", -1, 32'(ctrl), 32'h0);
        @(posedge clk); #1;
        clr = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            ir = tbl[i].ir; run = tbl[i].run; stop = tbl[i].stop; mem_done = tbl[i].md;
            @(negedge clk);
            check("step",    i, 32'(step),    32'(tbl[i].step));
            check("ctrl",    i, 32'(ctrl),    32'(tbl[i].ctrl));
            check("reg_in",  i, 32'(reg_in),  32'(tbl[i].rin));
            check("reg_out", i, 32'(reg_out), 32'(tbl[i].rout));
            check("alu_sel", i, 32'(alu_sel), 32'(tbl[i].alu));
            @(posedge clk); #1;
        end

        // Asynchronous clear out of HALT.
        run = 1'b0;
        clr = 1'b0;
        #1;
        check("clr_halt_step", -2, 32'(step), 32'd8);
        check("clr_halt_ctrl", -2, 32'(ctrl), 32'h0);
        #2 clr = 1'b1;
        @(negedge clk);
        check("idle_after_clr", -2, 32'(step), 32'd8);

        // Clear while ld is stalled in T6 with read high.
        @(posedge clk); #1;
        ir = IR_LD; run = 1'b1; mem_done = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            if (step == 4'd6) reached = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reach_t6", -3, 32'(reached), 32'd1);
        mem_done = 1'b0;
        #2;
        check("t6_read", -3, 32'(read), 32'd1);
        clr = 1'b0;
        #1;
        check("clr_t6_step", -3, 32'(step), 32'd8);
        check("clr_t6_ctrl", -3, 32'(ctrl), 32'h0);
        check("clr_t6_regs", -3, {reg_in, reg_out}, 32'h0);
        check("clr_t6_alu", -3, 32'(alu_sel), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
